// File: rtl/preg_free_list_pkg.sv
// Shared core configuration for the physical-register free list: sizes,
// derived widths and the preg / pointer types used by the rename block.
// PREG_SIZE must be a power of two so pointer arithmetic wraps naturally.
package preg_free_list_pkg;

    localparam int PREG_SIZE    = 128;
    localparam int ARCH_REGS    = 32;
    localparam int FETCH_WIDTH  = 4;
    localparam int COMMIT_WIDTH = 4;
    localparam int PREG_WIDTH   = $clog2(PREG_SIZE);

    // Number of pregs free straight out of reset; also the ceiling on free_count.
    localparam int FREE_INIT    = PREG_SIZE - ARCH_REGS;

    localparam int FETCH_CNT_W  = $clog2(FETCH_WIDTH + 1);
    localparam int COMMIT_CNT_W = $clog2(COMMIT_WIDTH + 1);

    typedef logic [PREG_WIDTH-1:0] preg_t;
    // Pointer: low bits index the storage, MSB is the wrap flag.
    typedef logic [PREG_WIDTH:0]   ptr_t;

    function automatic preg_t ptr_index(input ptr_t p);
        return p[PREG_WIDTH-1:0];
    endfunction

endpackage

// File: rtl/preg_free_list_if.sv
// Rename / commit / rollback port bundle of the free list. The master side
// is the pipeline (rename, ROB commit, walk logic); the slave is the list.
interface preg_free_list_if;
    import preg_free_list_pkg::*;

    logic [FETCH_WIDTH-1:0]    alloc_req;
    logic                      alloc_en;
    logic                      alloc_rdy;
    preg_t [FETCH_WIDTH-1:0]   alloc_prd;

    logic [COMMIT_WIDTH-1:0]   commit_en;
    logic [COMMIT_WIDTH-1:0]   commit_we;
    preg_t [COMMIT_WIDTH-1:0]  commit_old_prd;

    logic                      walk;
    logic [COMMIT_WIDTH-1:0]   walk_we;
    logic                      redirect;

    ptr_t                      free_count;

    modport master (
        output alloc_req, alloc_en, commit_en, commit_we, commit_old_prd,
               walk, walk_we, redirect,
        input  alloc_rdy, alloc_prd, free_count
    );

    modport slave (
        input  alloc_req, alloc_en, commit_en, commit_we, commit_old_prd,
               walk, walk_we, redirect,
        output alloc_rdy, alloc_prd, free_count
    );

endinterface

// File: rtl/preg_free_list_prefix_popcount.sv
// Exclusive prefix popcount: prefix[i] counts the set bits below bit i,
// total counts all set bits. Used to pack sparse slot requests onto
// consecutive free-list entries.
module prefix_popcount
    import preg_free_list_pkg::*;
#(
    parameter int N     = 4,
    parameter int CNT_W = $clog2(N + 1)
) (
    input  logic [N-1:0]            vec,
    output logic [N-1:0][CNT_W-1:0] prefix,
    output logic [CNT_W-1:0]        total
);

    logic [CNT_W-1:0] acc;

    // Ripple the running count across the slots.
    always_comb begin
        acc    = '0;
        prefix = '0;
        for (int i = 0; i < N; i++) begin
            prefix[i] = acc;
            acc       = acc + CNT_W'(vec[i]);
        end
        total = acc;
    end

endmodule

// File: rtl/preg_free_list.sv
// Physical register free list: a circular FIFO of preg numbers. Rename pops
// from head, commit pushes the previous mapping at tail, and a rollback walk
// rewinds head to hand squashed pregs back (their entries are still intact).
module preg_free_list
    import preg_free_list_pkg::*;
(
    input logic             clk,
    input logic             rst,
    preg_free_list_if.slave fl
);

    preg_t fifo [PREG_SIZE];
    ptr_t  head;
    ptr_t  tail;
    ptr_t  head_next;
    ptr_t  tail_next;

    logic [FETCH_WIDTH-1:0][FETCH_CNT_W-1:0]   alloc_prefix;
    logic [FETCH_CNT_W-1:0]                    alloc_total;
    logic [COMMIT_WIDTH-1:0]                   rel_mask;
    logic [COMMIT_WIDTH-1:0][COMMIT_CNT_W-1:0] rel_prefix;
    logic [COMMIT_CNT_W-1:0]                   rel_total;
    logic [COMMIT_CNT_W-1:0]                   walk_total;
    logic                                      alloc_fire;

    assign rel_mask   = fl.commit_en & fl.commit_we;
    assign walk_total = COMMIT_CNT_W'($countones(fl.walk_we));

    prefix_popcount #(.N(FETCH_WIDTH), .CNT_W(FETCH_CNT_W)) u_alloc_cnt (
        .vec    (fl.alloc_req),
        .prefix (alloc_prefix),
        .total  (alloc_total)
    );

    prefix_popcount #(.N(COMMIT_WIDTH), .CNT_W(COMMIT_CNT_W)) u_rel_cnt (
        .vec    (rel_mask),
        .prefix (rel_prefix),
        .total  (rel_total)
    );

    assign fl.free_count = tail - head;
    assign fl.alloc_rdy  = (fl.free_count >= ptr_t'(FETCH_WIDTH));
    // A flush or walk in flight means the rename group is dead; do not consume.
    assign alloc_fire    = fl.alloc_en & fl.alloc_rdy & ~fl.redirect & ~fl.walk;

    // Hand each requesting slot the next free entry past head, packed densely.
    always_comb begin
        fl.alloc_prd = '0;
        for (int i = 0; i < FETCH_WIDTH; i++) begin
            fl.alloc_prd[i] = fifo[ptr_index(head + ptr_t'(alloc_prefix[i]))];
        end
    end

    // Head rewinds on walk, otherwise advances by the granted allocations; tail
    // advances by the released count independently.
    always_comb begin
        head_next = head;
        if (fl.walk) begin
            head_next = head - ptr_t'(walk_total);
        end else if (alloc_fire) begin
            head_next = head + ptr_t'(alloc_total);
        end
        tail_next = tail + ptr_t'(rel_total);
    end

    // Pointer registers; reset leaves all non-architectural pregs free.
    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= ptr_t'(FREE_INIT);
        end else begin
            head <= head_next;
            tail <= tail_next;
        end
    end

    // Storage: reset seeds the free pregs in order, commit appends old mappings.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < PREG_SIZE; i++) begin
                fifo[i] <= preg_t'(ARCH_REGS + i);
            end
        end else begin
            for (int i = 0; i < COMMIT_WIDTH; i++) begin
                if (rel_mask[i]) begin
                    fifo[ptr_index(tail + ptr_t'(rel_prefix[i]))] <= fl.commit_old_prd[i];
                end
            end
        end
    end

    a_alloc_legal: assert property (@(posedge clk) disable iff (rst)
        !(fl.alloc_en && !fl.alloc_rdy));

    a_no_overflow: assert property (@(posedge clk) disable iff (rst)
        (ptr_t'(tail_next - head_next) <= ptr_t'(FREE_INIT)));

endmodule

// File: tb/tb_preg_free_list.sv
// Bench for preg_free_list: a queue model of the free pool predicts every
// granted preg and the free count; grants are scoreboarded per scenario.
module tb_preg_free_list;
    import preg_free_list_pkg::*;

    typedef logic [7:0] v8_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    preg_free_list_if bus ();

    preg_free_list dut (
        .clk (clk),
        .rst (rst),
        .fl  (bus)
    );

    int  checks = 0;
    int  errors = 0;
    v8_t exp_q[$];
    v8_t obs_q[$];
    int  free_q[$];
    int  hist[$];
    int  busy[$];

    task automatic idle_inputs();
        bus.alloc_req      = '0;
        bus.alloc_en       = 1'b0;
        bus.commit_en      = '0;
        bus.commit_we      = '0;
        bus.commit_old_prd = '0;
        bus.walk           = 1'b0;
        bus.walk_we        = '0;
        bus.redirect       = 1'b0;
    endtask

    task automatic model_reset();
        free_q.delete();
        hist.delete();
        busy.delete();
        exp_q.delete();
        obs_q.delete();
        for (int i = 0; i < PREG_SIZE - ARCH_REGS; i++) free_q.push_back(ARCH_REGS + i);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    // One cycle of stimulus; the model predicts grants and records observations.
    task automatic step(input logic [3:0] req, input logic en, input logic [3:0] cen,
                        input logic [3:0] cwe, input preg_t [3:0] old, input logic wk,
                        input logic [3:0] wwe, input logic rd);
        logic fire;
        int   p;
        bus.alloc_req      = req;
        bus.alloc_en       = en;
        bus.commit_en      = cen;
        bus.commit_we      = cwe;
        bus.commit_old_prd = old;
        bus.walk           = wk;
        bus.walk_we        = wwe;
        bus.redirect       = rd;
        fire = en && (free_q.size() >= FETCH_WIDTH) && !rd && !wk;
        @(negedge clk);
        if (fire) begin
            for (int i = 0; i < 4; i++) begin
                if (req[i]) begin
                    p = free_q.pop_front();
                    hist.push_back(p);
                    exp_q.push_back(v8_t'(p));
                    obs_q.push_back(v8_t'(bus.alloc_prd[i]));
                end
            end
        end
        for (int i = 0; i < 4; i++) begin
            if (cen[i] && cwe[i]) free_q.push_back(int'(old[i]));
        end
        if (wk) begin
            for (int i = 0; i < 4; i++) begin
                if (wwe[i]) free_q.push_front(hist.pop_back());
            end
        end
        @(posedge clk);
        #1;
        idle_inputs();
    endtask

    task automatic test_reset();
        // Reset must win over a simultaneous alloc, commit and walk.
        rst                = 1'b1;
        bus.alloc_req      = 4'b1111;
        bus.alloc_en       = 1'b1;
        bus.commit_en      = 4'b1111;
        bus.commit_we      = 4'b1111;
        bus.commit_old_prd = {4{7'd3}};
        bus.walk           = 1'b1;
        bus.walk_we        = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        idle_inputs();
        rst = 1'b0;
        model_reset();
        checks++;
        if (bus.free_count !== 8'd96) begin
            errors++;
            $display("FAIL reset_free_count got %0d expected 96", bus.free_count);
        end
        checks++;
        if (bus.alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL reset_alloc_rdy got %b expected 1", bus.alloc_rdy);
        end
        bus.alloc_req = 4'b1111;
        #1;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (bus.alloc_prd[i] !== preg_t'(ARCH_REGS + i)) begin
                errors++;
                $display("FAIL reset_alloc_prd slot%0d got %0d expected %0d", i, bus.alloc_prd[i], ARCH_REGS + i);
            end
        end
        bus.alloc_req = '0;
    endtask

    task automatic test_alloc_full();
        v8_t e, o;
        do_reset();
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL alloc_full_prd got %0d expected %0d", o, e);
            end
        end
        checks++;
        if (bus.free_count !== 8'd92) begin
            errors++;
            $display("FAIL alloc_full_count got %0d expected 92", bus.free_count);
        end
    endtask

    task automatic test_alloc_sparse();
        v8_t e, o;
        do_reset();
        step(4'b1010, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        checks++;
        if (obs_q.size() != 2 || obs_q[0] !== 8'd32 || obs_q[1] !== 8'd33) begin
            errors++;
            $display("FAIL sparse_slots got n=%0d s1=%0d s3=%0d expected s1=32 s3=33",
                     obs_q.size(), obs_q[0], obs_q[1]);
        end
        checks++;
        if (bus.free_count !== 8'd94) begin
            errors++;
            $display("FAIL sparse_count got %0d expected 94", bus.free_count);
        end
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL sparse_prd got %0d expected %0d", o, e);
            end
        end
    endtask

    task automatic test_commit();
        v8_t e, o;
        int  last_exp[4];
        last_exp = '{5, 7, 13, 11};
        do_reset();
        repeat (2) step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        // Slot 1 commits without writing rd: its old_prd must not be released.
        step(4'b0, 1'b0, 4'b0111, 4'b0101, {7'd0, 7'd7, 7'd9, 7'd5}, 1'b0, 4'b0, 1'b0);
        checks++;
        if (bus.free_count !== 8'd90) begin
            errors++;
            $display("FAIL commit_count got %0d expected 90", bus.free_count);
        end
        step(4'b0, 1'b0, 4'b1010, 4'b1010, {7'd11, 7'd0, 7'd13, 7'd0}, 1'b0, 4'b0, 1'b0);
        checks++;
        if (bus.free_count !== v8_t'(free_q.size())) begin
            errors++;
            $display("FAIL commit_count2 got %0d expected %0d", bus.free_count, free_q.size());
        end
        for (int c = 0; c < 22; c++) step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL commit_drain_prd got %0d expected %0d", o, e);
            end
        end
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k] !== v8_t'(last_exp[k])) begin
                errors++;
                $display("FAIL commit_released_prd slot%0d got %0d expected %0d", k, obs_q[k], last_exp[k]);
            end
        end
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (bus.free_count !== 8'd0 || bus.alloc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL commit_empty got count=%0d rdy=%b expected count=0 rdy=0", bus.free_count, bus.alloc_rdy);
        end
    endtask

    task automatic test_walk();
        v8_t e, o;
        do_reset();
        repeat (2) step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        exp_q.delete();
        obs_q.delete();
        checks++;
        if (bus.free_count !== 8'd88) begin
            errors++;
            $display("FAIL walk_pre_count got %0d expected 88", bus.free_count);
        end
        step(4'b0, 1'b0, 4'b0, 4'b0, '0, 1'b1, 4'b1111, 1'b0);
        // Rename tries to fire during the walk; it must be ignored.
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b1, 4'b1111, 1'b0);
        checks++;
        if (bus.free_count !== 8'd96) begin
            errors++;
            $display("FAIL walk_count got %0d expected 96", bus.free_count);
        end
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (obs_q[k] !== v8_t'(32 + k)) begin
                errors++;
                $display("FAIL walk_realloc slot%0d got %0d expected %0d", k, obs_q[k], 32 + k);
            end
        end
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL walk_prd got %0d expected %0d", o, e);
            end
        end
    endtask

    task automatic test_drain();
        v8_t e, o;
        do_reset();
        repeat (23) step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        checks++;
        if (bus.free_count !== 8'd4 || bus.alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL drain_four got count=%0d rdy=%b expected count=4 rdy=1", bus.free_count, bus.alloc_rdy);
        end
        step(4'b0001, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        checks++;
        if (bus.free_count !== 8'd3 || bus.alloc_rdy !== 1'b0) begin
            errors++;
            $display("FAIL drain_three got count=%0d rdy=%b expected count=3 rdy=0", bus.free_count, bus.alloc_rdy);
        end
        step(4'b0, 1'b0, 4'b0001, 4'b0001, {7'd0, 7'd0, 7'd0, 7'd50}, 1'b0, 4'b0, 1'b0);
        checks++;
        if (bus.free_count !== 8'd4 || bus.alloc_rdy !== 1'b1) begin
            errors++;
            $display("FAIL drain_release got count=%0d rdy=%b expected count=4 rdy=1", bus.free_count, bus.alloc_rdy);
        end
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b0);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            o = obs_q.pop_front();
            checks++;
            if (o !== e) begin
                errors++;
                $display("FAIL drain_prd got %0d expected %0d", o, e);
            end
        end
    endtask

    task automatic test_wrap_redirect();
        v8_t         e, o;
        logic [3:0]  req, cen, cwe;
        logic        en;
        preg_t [3:0] old;
        int          total_alloc, total_rel, fc;
        do_reset();
        total_alloc = 0;
        total_rel   = 0;
        for (int c = 0; c < 200; c++) begin
            req = 4'($urandom_range(0, 15));
            en  = (free_q.size() >= FETCH_WIDTH) && ($urandom_range(0, 3) != 0);
            cen = 4'($urandom_range(0, 15));
            cwe = 4'($urandom_range(0, 15));
            old = '0;
            for (int i = 0; i < 4; i++) begin
                if (cen[i] && cwe[i]) begin
                    if (busy.size() > 0) begin
                        old[i] = preg_t'(busy.pop_front());
                        total_rel++;
                    end else begin
                        cwe[i] = 1'b0;
                    end
                end
            end
            step(req, en, cen, cwe, old, 1'b0, 4'b0, 1'b0);
            total_alloc += exp_q.size();
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                o = obs_q.pop_front();
                busy.push_back(int'(e));
                checks++;
                if (o !== e) begin
                    errors++;
                    $display("FAIL wrap_prd cycle %0d got %0d expected %0d", c, o, e);
                end
            end
            checks++;
            if (bus.free_count !== v8_t'(free_q.size())) begin
                errors++;
                $display("FAIL wrap_count cycle %0d got %0d expected %0d", c, bus.free_count, free_q.size());
            end
        end
        checks++;
        if (dut.head !== v8_t'(total_alloc) || dut.tail !== v8_t'(96 + total_rel)) begin
            errors++;
            $display("FAIL wrap_pointers got head=%0d tail=%0d expected head=%0d tail=%0d",
                     dut.head, dut.tail, total_alloc % 256, (96 + total_rel) % 256);
        end
        // Free up room so a rename attempt under redirect is legal.
        old = '0;
        for (int i = 0; i < 4; i++) begin
            old[i] = preg_t'(busy.pop_front());
            total_rel++;
        end
        step(4'b0, 1'b0, 4'b1111, 4'b1111, old, 1'b0, 4'b0, 1'b0);
        fc = free_q.size();
        step(4'b1111, 1'b1, 4'b0, 4'b0, '0, 1'b0, 4'b0, 1'b1);
        checks++;
        if (bus.free_count !== v8_t'(fc) || dut.head !== v8_t'(total_alloc) || obs_q.size() != 0) begin
            errors++;
            $display("FAIL redirect_hold got count=%0d head=%0d expected count=%0d head=%0d",
                     bus.free_count, dut.head, fc, total_alloc % 256);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_alloc_full();
        test_alloc_sparse();
        test_commit();
        test_walk();
        test_drain();
        test_wrap_redirect();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/preg_free_list.md
PREG_FREE_LIST -- requirements
Module: preg_free_list

Interface
REQ-001 Parameter PREG_SIZE, default 128, number of physical registers; PREG_WIDTH = log2(PREG_SIZE).
REQ-002 Parameter ARCH_REGS, default 32, pregs 0..ARCH_REGS-1 mapped at reset and never initially free.
REQ-003 Parameter FETCH_WIDTH, default 4, rename slots per cycle; COMMIT_WIDTH, default 4, commit/walk slots per cycle.
REQ-004 clk  in  1  clock; all state updates on posedge clk.
REQ-005 rst  in  1  reset, synchronous, active-high.
REQ-006 alloc_req  in  FETCH_WIDTH  per-slot request for a new preg (slot writes rd).
REQ-007 alloc_en  in  1  rename fires this cycle; consumes pregs for every set alloc_req bit.
REQ-008 alloc_rdy  out  1  free_count >= FETCH_WIDTH; rename must not assert alloc_en while low.
REQ-009 alloc_prd  out  FETCH_WIDTH x PREG_WIDTH  preg assigned to each requesting slot; combinational from current state.
REQ-010 commit_en, commit_we  in  COMMIT_WIDTH each  committing slot valid / slot wrote rd.
REQ-011 commit_old_prd  in  COMMIT_WIDTH x PREG_WIDTH  previous mapping of rd, released to free list.
REQ-012 walk  in  1  rollback walk active; walk_we  in  COMMIT_WIDTH  walked slot had allocated a preg.
REQ-013 redirect  in  1  backend flush this cycle.
REQ-014 free_count  out  PREG_WIDTH+1  number of free pregs held.

Function
REQ-015 Storage: circular FIFO of PREG_SIZE entries x PREG_WIDTH; head and tail pointers PREG_WIDTH+1 bits (MSB = wrap flag).
REQ-016 free_count = tail - head, modulo 2^(PREG_WIDTH+1); full = equal index, differing wrap; empty = equal pointers.
REQ-017 alloc_prd[i] = fifo[head + popcount(alloc_req[i-1:0])]; slots without request output don't-care.
REQ-018 Allocation fires when alloc_en & alloc_rdy & ~redirect & ~walk; head advances by popcount(alloc_req) next cycle.
REQ-019 Release: for each slot with commit_en & commit_we, write commit_old_prd to fifo[tail + popcount of such prior slots]; tail advances by total count next cycle.
REQ-020 Walk: when walk, head moves back by popcount(walk_we), returning squashed pregs (entries still intact in storage).
REQ-021 Commit release and walk/allocation may occur in the same cycle; head and tail update independently.
REQ-022 redirect or walk suppresses allocation that cycle; alloc_rdy still reflects free_count.
REQ-023 alloc_prd reflects the pre-update head; newly released entries usable the cycle after the tail update.
REQ-024 free_count never exceeds PREG_SIZE-ARCH_REGS; release beyond that or alloc_en with alloc_rdy low is illegal (assertion).
REQ-025 Pointer arithmetic wraps modulo PREG_SIZE on index, toggling wrap bit.

Reset
REQ-026 On rst: fifo[i] = ARCH_REGS+i for i < PREG_SIZE-ARCH_REGS; head = 0; tail = PREG_SIZE-ARCH_REGS; free_count = 96 at defaults; alloc_rdy = 1.
REQ-027 rst overrides any simultaneous alloc, commit or walk; contents beyond tail unspecified.

Structure
REQ-028 PREG_SIZE, ARCH_REGS, FETCH_WIDTH, COMMIT_WIDTH, PREG_WIDTH and pointer typedef live in the shared core package.
REQ-029 One sub-module, prefix_popcount: N-bit vector -> per-bit exclusive prefix counts plus total; instantiated for allocation and release.

Verification
REQ-030 Reset, alloc_req=1111, alloc_en=1 -> alloc_prd = 32,33,34,35; next cycle free_count = 92.
REQ-031 Reset, alloc_req=1010 -> slot1 = 32, slot3 = 33; head +2; free_count 94.
REQ-032 Commit old_prd 5,7 on slots 0,2 with we; slot 1 en without we -> fifo[96],fifo[97] = 5,7; free_count +2.
REQ-033 Allocate 8 pregs over 2 cycles, then walk with walk_we=1111 twice -> free_count back to 96; next alloc returns 32,33,34,35 again.
REQ-034 Drain to free_count = 3 -> alloc_rdy = 0; one release -> alloc_rdy = 1 next cycle.
REQ-035 Cycle 200 allocs/releases so pointers wrap -> indices wrap at 128, wrap bit toggles, free_count correct; redirect cycle with alloc_en -> head unchanged.
